// File: rtl/rbus_mb_slot_inserter_if.sv
// Ring tap interface for rbus_mb_slot_inserter.
// Groups, per bus, the ring in/out words, the local TX write port and status.
// The o_ins_cnt lane exists only when RBUS_MB_SLOT_INSERTER_STATS_EN is defined.
interface rbus_mb_slot_inserter_if #(
  parameter int BUS_NUM = 1
);
  logic        i_sof     [BUS_NUM-1:0];
  logic [11:0] i_ctrl    [BUS_NUM-1:0];
  logic [71:0] i_data    [BUS_NUM-1:0];
  logic        o_sof     [BUS_NUM-1:0];
  logic [11:0] o_ctrl    [BUS_NUM-1:0];
  logic [71:0] o_data    [BUS_NUM-1:0];
  logic        i_wr_stb  [BUS_NUM-1:0];
  logic [11:0] i_wr_ctrl [BUS_NUM-1:0];
  logic [71:0] i_wr_data [BUS_NUM-1:0];
  logic        o_wr_rdy  [BUS_NUM-1:0];
  logic        o_err     [BUS_NUM-1:0];
`ifdef RBUS_MB_SLOT_INSERTER_STATS_EN
  logic [15:0] o_ins_cnt [BUS_NUM-1:0];

  modport slave (
    input  i_sof, i_ctrl, i_data, i_wr_stb, i_wr_ctrl, i_wr_data,
    output o_sof, o_ctrl, o_data, o_wr_rdy, o_err, o_ins_cnt
  );

  modport master (
    output i_sof, i_ctrl, i_data, i_wr_stb, i_wr_ctrl, i_wr_data,
    input  o_sof, o_ctrl, o_data, o_wr_rdy, o_err, o_ins_cnt
  );
`else
  modport slave (
    input  i_sof, i_ctrl, i_data, i_wr_stb, i_wr_ctrl, i_wr_data,
    output o_sof, o_ctrl, o_data, o_wr_rdy, o_err
  );

  modport master (
    output i_sof, i_ctrl, i_data, i_wr_stb, i_wr_ctrl, i_wr_data,
    input  o_sof, o_ctrl, o_data, o_wr_rdy, o_err
  );
`endif
endinterface

// File: rtl/rbus_mb_slot_inserter.sv
// rbus_mb_slot_inserter: BUS_NUM independent ring taps. Each tap buffers
// complete frames written locally and drops each into the next free slot
// (header ctrl[11]=0) passing on its ring; everything else passes through
// with one register of latency.
// Optional feature macro: RBUS_MB_SLOT_INSERTER_STATS_EN adds a saturating
// per-bus count of completed insertions on o_ins_cnt.
module rbus_mb_slot_inserter #(
  parameter int BUS_NUM   = 1,
  parameter int FRAME_LEN = 4,
  parameter int FIFO_AW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rbus_mb_slot_inserter_if.slave bus
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   PTR_DEPTH = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   PTR_FLEN  = (FIFO_AW+1)'(FRAME_LEN);
  localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   PTR_ZERO  = (FIFO_AW+1)'(0);
  localparam logic [FIFO_AW-1:0] CNT_LAST  = FIFO_AW'(FRAME_LEN-1);
  localparam logic [FIFO_AW-1:0] CNT_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW-1:0] CNT_ZERO  = FIFO_AW'(0);

  typedef enum logic [0:0] {
    ST_PASS   = 1'b0,
    ST_INSERT = 1'b1
  } state_t;

  for (genvar b = 0; b < BUS_NUM; b++) begin : g_bus
    logic [83:0]        r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [FIFO_AW:0]   r_base;
    logic [FIFO_AW:0]   r_frames_rdy;
    logic [FIFO_AW-1:0] r_wcnt;
    logic [FIFO_AW-1:0] r_cnt;
    state_t             r_state;
    logic               r_sof;
    logic [11:0]        r_ctrl;
    logic [71:0]        r_data;
    logic               r_err;
    logic               r_wr_rdy;

    logic               w_wr_acc;
    logic               w_commit;
    logic               w_free_slot;
    logic               w_early_sof;
    logic [FIFO_AW:0]   w_drop_ptr;
    logic [FIFO_AW:0]   w_wr_ptr_nxt;
    logic [FIFO_AW:0]   w_rd_ptr_nxt;
    logic [FIFO_AW:0]   w_base_nxt;
    logic [FIFO_AW:0]   w_start_ptr;
    logic [FIFO_AW:0]   w_emit_ptr;
    logic [FIFO_AW:0]   w_frames_nxt;
    logic [FIFO_AW-1:0] w_cnt_nxt;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_emit;
    logic               w_emit_hdr;
    logic               w_frame_done;
    logic               w_frame_drop;
    logic [83:0]        w_head;
    logic               w_sof_nxt;
    logic [11:0]        w_ctrl_nxt;
    logic [71:0]        w_data_nxt;

    assign w_wr_acc     = bus.i_wr_stb[b] & r_wr_rdy;
    assign w_commit     = w_wr_acc & (r_wcnt == CNT_LAST);
    assign w_free_slot  = bus.i_sof[b] & ~bus.i_ctrl[b][11];
    assign w_early_sof  = bus.i_sof[b] & (r_cnt != CNT_LAST);
    assign w_drop_ptr   = r_base + PTR_FLEN;
    assign w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_head       = r_mem[w_emit_ptr[FIFO_AW-1:0]];

    // Local frame buffer write port; read side is asynchronous
    always_ff @(posedge clk) begin
      if (w_wr_acc) begin
        r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {bus.i_wr_ctrl[b], bus.i_wr_data[b]};
      end
    end

    // Slot FSM next state, read pointer movement and emit selection
    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_base_nxt   = r_base;
      w_rd_ptr_nxt = r_rd_ptr;
      w_start      = 1'b0;
      w_start_ptr  = r_rd_ptr;
      w_emit       = 1'b0;
      w_emit_hdr   = 1'b0;
      w_emit_ptr   = r_rd_ptr;
      w_frame_done = 1'b0;
      w_frame_drop = 1'b0;
      case (r_state)
        ST_PASS: begin
          w_start     = w_free_slot & (r_frames_rdy != PTR_ZERO);
          w_start_ptr = r_rd_ptr;
        end
        ST_INSERT: begin
          if (w_early_sof) begin
            // Slot cut short: discard the rest of this frame; the new
            // header may take the next frame only if one remains queued.
            w_frame_drop = 1'b1;
            w_rd_ptr_nxt = w_drop_ptr;
            w_state_nxt  = ST_PASS;
            w_cnt_nxt    = CNT_ZERO;
            w_start_ptr  = w_drop_ptr;
            w_start      = w_free_slot & (r_frames_rdy > PTR_ONE);
          end else begin
            w_emit       = 1'b1;
            w_emit_ptr   = r_rd_ptr;
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            if (r_cnt == CNT_LAST) begin
              w_frame_done = 1'b1;
              w_state_nxt  = ST_PASS;
              w_cnt_nxt    = CNT_ZERO;
            end else begin
              w_cnt_nxt    = r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_PASS;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
      // Header word (cnt=0) is emitted in the cycle the free slot arrives
      if (w_start) begin
        w_emit       = 1'b1;
        w_emit_hdr   = 1'b1;
        w_emit_ptr   = w_start_ptr;
        w_base_nxt   = w_start_ptr;
        w_rd_ptr_nxt = w_start_ptr + PTR_ONE;
        w_cnt_nxt    = CNT_ONE;
        w_state_nxt  = ST_INSERT;
      end else begin
        w_emit_hdr   = 1'b0;
      end
    end

    // Ring output word select: FIFO head while inserting, else the ring input
    always_comb begin
      w_sof_nxt  = bus.i_sof[b];
      w_ctrl_nxt = bus.i_ctrl[b];
      w_data_nxt = bus.i_data[b];
      if (w_emit) begin
        w_sof_nxt  = w_emit_hdr;
        w_ctrl_nxt = w_head[83:72] | (w_emit_hdr ? 12'h800 : 12'h000);
        w_data_nxt = w_head[71:0];
      end else begin
        w_sof_nxt  = bus.i_sof[b];
      end
    end

    // Committed-frame count: one up per commit, one down per finished or dropped frame
    always_comb begin
      w_frames_nxt = r_frames_rdy;
      if (w_commit && !(w_frame_done || w_frame_drop)) begin
        w_frames_nxt = r_frames_rdy + PTR_ONE;
      end else if (!w_commit && (w_frame_done || w_frame_drop)) begin
        w_frames_nxt = r_frames_rdy - PTR_ONE;
      end else begin
        w_frames_nxt = r_frames_rdy;
      end
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_state      <= ST_PASS;
        r_cnt        <= CNT_ZERO;
        r_wcnt       <= CNT_ZERO;
        r_wr_ptr     <= PTR_ZERO;
        r_rd_ptr     <= PTR_ZERO;
        r_base       <= PTR_ZERO;
        r_frames_rdy <= PTR_ZERO;
        r_sof        <= 1'b0;
        r_ctrl       <= 12'h000;
        r_data       <= 72'h0;
        r_err        <= 1'b0;
        r_wr_rdy     <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_cnt        <= w_cnt_nxt;
        r_base       <= w_base_nxt;
        r_rd_ptr     <= w_rd_ptr_nxt;
        r_wr_ptr     <= w_wr_ptr_nxt;
        r_frames_rdy <= w_frames_nxt;
        if (w_wr_acc) begin
          r_wcnt <= (r_wcnt == CNT_LAST) ? CNT_ZERO : (r_wcnt + CNT_ONE);
        end
        r_sof        <= w_sof_nxt;
        r_ctrl       <= w_ctrl_nxt;
        r_data       <= w_data_nxt;
        r_err        <= r_err | w_frame_drop;
        r_wr_rdy     <= (w_wr_ptr_nxt - w_rd_ptr_nxt) != PTR_DEPTH;
      end
    end

    assign bus.o_sof[b]    = r_sof;
    assign bus.o_ctrl[b]   = r_ctrl;
    assign bus.o_data[b]   = r_data;
    assign bus.o_err[b]    = r_err;
    assign bus.o_wr_rdy[b] = r_wr_rdy;

`ifdef RBUS_MB_SLOT_INSERTER_STATS_EN
    logic [15:0] r_ins_cnt;

    // Saturating count of insertions that ran to the last word
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_ins_cnt <= 16'h0000;
      end else if (w_frame_done && (r_ins_cnt != 16'hFFFF)) begin
        r_ins_cnt <= r_ins_cnt + 16'h0001;
      end
    end

    assign bus.o_ins_cnt[b] = r_ins_cnt;
`endif
  end

endmodule

// File: tb/tb_rbus_mb_slot_inserter.sv
// Directed bench for rbus_mb_slot_inserter (BUS_NUM=1, FRAME_LEN=4, FIFO_AW=3).
module tb_rbus_mb_slot_inserter;

  localparam int BUS_NUM   = 1;
  localparam int FRAME_LEN = 4;
  localparam int FIFO_AW   = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  rbus_mb_slot_inserter_if #(.BUS_NUM(BUS_NUM)) bus ();

  rbus_mb_slot_inserter #(
    .BUS_NUM  (BUS_NUM),
    .FRAME_LEN(FRAME_LEN),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [83:0] got, input logic [83:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sof, input logic [11:0] ctrl, input logic [71:0] data);
    bus.i_sof[0]  = sof;
    bus.i_ctrl[0] = ctrl;
    bus.i_data[0] = data;
  endtask

  task automatic wr_set(input logic stb, input logic [83:0] w);
    bus.i_wr_stb[0]  = stb;
    bus.i_wr_ctrl[0] = w[83:72];
    bus.i_wr_data[0] = w[71:0];
  endtask

  task automatic expect_out(input string tag, input logic sof, input logic [11:0] ctrl,
                            input logic [71:0] data);
    chk({tag, ".sof"},  {83'd0, bus.o_sof[0]},  {83'd0, sof});
    chk({tag, ".ctrl"}, {72'd0, bus.o_ctrl[0]}, {72'd0, ctrl});
    chk({tag, ".data"}, {12'd0, bus.o_data[0]}, {12'd0, data});
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    chk(tag, {83'd0, got}, {83'd0, exp});
  endtask

  // Word idx of local frame fr: ctrl[11]=0 so the forced busy bit is visible.
  function automatic logic [83:0] wd(input logic [7:0] fr, input logic [3:0] idx);
    return {4'h2, fr[3:0], idx, fr, 56'h0123_4567_89AB_CD, 4'h0, idx};
  endfunction

  task automatic write_word(input logic [7:0] fr, input logic [3:0] idx);
    wr_set(1'b1, wd(fr, idx));
    tick();
    wr_set(1'b0, 84'h0);
  endtask

  task automatic write_frame(input logic [7:0] fr);
    drive(1'b0, 12'h000, 72'h0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      write_word(fr, 4'(i));
    end
  endtask

  // Present a free slot and expect frame fr to occupy it.
  task automatic expect_frame(input string tag, input logic [7:0] fr);
    logic [83:0] w;
    for (int i = 0; i < FRAME_LEN; i++) begin
      w = wd(fr, 4'(i));
      if (i == 0) begin
        drive(1'b1, 12'h000, 72'hFF_EEEE_DDDD_CCCC_BBBB);
      end else begin
        drive(1'b0, 12'h0A5, 72'h55_AAAA_5555_AAAA_5555);
      end
      tick();
      expect_out($sformatf("%s.w%0d", tag, i), (i == 0),
                 (i == 0) ? (w[83:72] | 12'h800) : w[83:72], w[71:0]);
    end
    drive(1'b0, 12'h000, 72'h0);
  endtask

  // Present a free slot header and expect it to pass unchanged.
  task automatic expect_free_pass(input string tag);
    drive(1'b1, 12'h03C, 72'h12_3456_789A_BCDE_F012);
    tick();
    expect_out(tag, 1'b1, 12'h03C, 72'h12_3456_789A_BCDE_F012);
    drive(1'b0, 12'h000, 72'h0);
    tick();
  endtask

  initial begin
    logic [83:0] w;
    rst = 1'b0;
    drive(1'b0, 12'h000, 72'h0);
    wr_set(1'b0, 84'h0);

    // 1. reset held three cycles, then release
    tick(); tick(); tick();
    expect_out("rst", 1'b0, 12'h000, 72'h0);
    expect_bit("rst.err", bus.o_err[0], 1'b0);
    expect_bit("rst.rdy", bus.o_wr_rdy[0], 1'b0);
    rst = 1'b1;
    tick();
    expect_bit("rel.rdy", bus.o_wr_rdy[0], 1'b1);

    // 2. passthrough with an empty FIFO
    drive(1'b1, 12'h9F3, 72'hAB_CDEF_0123_4567_89AB);
    tick();
    expect_out("pass.busy", 1'b1, 12'h9F3, 72'hAB_CDEF_0123_4567_89AB);
    drive(1'b0, 12'h7FF, 72'hFF_FFFF_FFFF_FFFF_FFFF);
    tick();
    expect_out("pass.body", 1'b0, 12'h7FF, 72'hFF_FFFF_FFFF_FFFF_FFFF);
    expect_free_pass("pass.free");

    // 3. one frame lands in the first free slot, then FIFO is empty
    write_frame(8'h01);
    expect_frame("ins1", 8'h01);
    expect_free_pass("ins1.empty");

    // 4. busy slot passes, the queued frame takes the following free slot
    write_frame(8'h02);
    drive(1'b1, 12'h8AB, 72'h11_2233_4455_6677_8899);
    tick();
    expect_out("busy.hdr", 1'b1, 12'h8AB, 72'h11_2233_4455_6677_8899);
    drive(1'b0, 12'h0CD, 72'h99_8877_6655_4433_2211);
    tick();
    expect_out("busy.body", 1'b0, 12'h0CD, 72'h99_8877_6655_4433_2211);
    tick(); tick();
    expect_frame("ins2", 8'h02);

    // 5. fill all 8 words: not ready, 9th write ignored, room after one insert
    write_frame(8'h03);
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      write_word(8'h04, 4'(i));
    end
    expect_bit("full.rdy7", bus.o_wr_rdy[0], 1'b1);
    write_word(8'h04, 4'(FRAME_LEN - 1));
    expect_bit("full.rdy8", bus.o_wr_rdy[0], 1'b0);
    write_word(8'hEE, 4'h0);
    expect_bit("full.rdy9", bus.o_wr_rdy[0], 1'b0);
    expect_frame("full.f3", 8'h03);
    expect_bit("full.rdy_after", bus.o_wr_rdy[0], 1'b1);
    expect_frame("full.f4", 8'h04);
    expect_free_pass("full.empty");

    // 6. early sof at cnt=2 with two frames queued
    write_frame(8'h05);
    write_frame(8'h06);
    w = wd(8'h05, 4'h0);
    drive(1'b1, 12'h000, 72'h0);
    tick();
    expect_out("early.g0", 1'b1, w[83:72] | 12'h800, w[71:0]);
    w = wd(8'h05, 4'h1);
    drive(1'b0, 12'h000, 72'h0);
    tick();
    expect_out("early.g1", 1'b0, w[83:72], w[71:0]);
    expect_bit("early.err0", bus.o_err[0], 1'b0);
    drive(1'b1, 12'h000, 72'h0);
    tick();
    w = wd(8'h06, 4'h0);
    expect_out("early.h0", 1'b1, w[83:72] | 12'h800, w[71:0]);
    expect_bit("early.err1", bus.o_err[0], 1'b1);
    for (int i = 1; i < FRAME_LEN; i++) begin
      w = wd(8'h06, 4'(i));
      drive(1'b0, 12'h000, 72'h0);
      tick();
      expect_out($sformatf("early.h%0d", i), 1'b0, w[83:72], w[71:0]);
    end
    expect_free_pass("early.empty");
    expect_bit("early.rdy", bus.o_wr_rdy[0], 1'b1);

    // 6b. early sof with a single frame queued: header passes, frame is dropped
    write_frame(8'h09);
    w = wd(8'h09, 4'h0);
    drive(1'b1, 12'h000, 72'h0);
    tick();
    expect_out("drop.k0", 1'b1, w[83:72] | 12'h800, w[71:0]);
    drive(1'b1, 12'h001, 72'h0F_0F0F_0F0F_0F0F_0F0F);
    tick();
    expect_out("drop.pass", 1'b1, 12'h001, 72'h0F_0F0F_0F0F_0F0F_0F0F);
    drive(1'b0, 12'h000, 72'h0);
    tick();
    expect_free_pass("drop.empty");
    expect_bit("drop.err", bus.o_err[0], 1'b1);

    // 7. commit coinciding with the last inserted word keeps frames_rdy at 1
    write_frame(8'h07);
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      write_word(8'h08, 4'(i));
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      w = wd(8'h07, 4'(i));
      drive(i == 0, 12'h000, 72'h0);
      if (i == FRAME_LEN - 1) begin
        wr_set(1'b1, wd(8'h08, 4'(FRAME_LEN - 1)));
      end
      tick();
      wr_set(1'b0, 84'h0);
      expect_out($sformatf("coin.l%0d", i), (i == 0),
                 (i == 0) ? (w[83:72] | 12'h800) : w[83:72], w[71:0]);
    end
    drive(1'b0, 12'h000, 72'h0);
    tick();
    expect_frame("coin.m", 8'h08);
    expect_free_pass("coin.empty");

    // 8. reset clears the sticky error
    rst = 1'b0;
    tick();
    expect_bit("rst2.err", bus.o_err[0], 1'b0);
    expect_bit("rst2.rdy", bus.o_wr_rdy[0], 1'b0);
    rst = 1'b1;
    tick();
    expect_bit("rst2.rdy_rel", bus.o_wr_rdy[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
